// File: rtl/plic_hw_claim_ctrl.sv
// plic_hw_claim_ctrl: per-target hardware claim/complete sequencer between plic_core and CPU vectored-interrupt ports
module plic_hw_claim_ctrl #(
  parameter int SOURCES      = 35,
  parameter int TARGETS      = 4,
  parameter int GUARD_CYCLES = 2,
  localparam int SOURCES_BITS = $clog2(SOURCES + 1)
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [TARGETS-1:0]                hw_en,
  input  logic [TARGETS-1:0]                ireq,
  input  logic [TARGETS*SOURCES_BITS-1:0]   id,
  output logic [TARGETS-1:0]                claim,
  output logic [TARGETS-1:0]                complete,
  output logic [TARGETS-1:0]                irq_req,
  output logic [TARGETS*SOURCES_BITS-1:0]   irq_id,
  input  logic [TARGETS-1:0]                irq_ack,
  output logic [TARGETS-1:0]                irq_active,
  input  logic [TARGETS-1:0]                eoi,
  input  logic [TARGETS*SOURCES_BITS-1:0]   eoi_id,
  output logic [TARGETS-1:0]                eoi_err
);
  localparam int SB = SOURCES_BITS;
  // A zero-cycle guard still needs a legal one-bit counter
  localparam int CW = GUARD_CYCLES > 0 ? $clog2(GUARD_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, OFFER, ACTIVE, GUARD} state_t;
  for (genvar t = 0; t < TARGETS; t++) begin : g_tgt
    state_t st, st_n;
    logic [SB-1:0] id_in, eoi_in, id_q, id_n;
    logic [CW-1:0] cnt, cnt_n;
    logic req_q, req_n, act_q, act_n, clm_q, clm_n, cmp_q, cmp_n, err_q, err_n;
    assign id_in  = id[t*SB +: SB];
    assign eoi_in = eoi_id[t*SB +: SB];
    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        st    <= IDLE;
        id_q  <= '0;
        cnt   <= '0;
        req_q <= 1'b0;
        act_q <= 1'b0;
        clm_q <= 1'b0;
        cmp_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        st    <= st_n;
        id_q  <= id_n;
        cnt   <= cnt_n;
        req_q <= req_n;
        act_q <= act_n;
        clm_q <= clm_n;
        cmp_q <= cmp_n;
        err_q <= err_n;
      end
    end
    always_comb begin
      st_n  = st;
      id_n  = id_q;
      cnt_n = cnt;
      req_n = req_q;
      act_n = act_q;
      clm_n = 1'b0;
      cmp_n = 1'b0;
      err_n = eoi[t] && st != ACTIVE;
      case (st)
        IDLE:
          if (hw_en[t] && ireq[t] && id_in != '0) begin
            id_n  = id_in;
            req_n = 1'b1;
            st_n  = OFFER;
          end
        OFFER:
          if (irq_ack[t]) begin
            clm_n = 1'b1;
            req_n = 1'b0;
            act_n = 1'b1;
            st_n  = ACTIVE;
          end else if (!ireq[t] || !hw_en[t]) begin
            req_n = 1'b0;
            id_n  = '0;
            st_n  = IDLE;
          end
        ACTIVE:
          if (eoi[t] && eoi_in == id_q) begin
            cmp_n = 1'b1;
            act_n = 1'b0;
            id_n  = '0;
            cnt_n = CW'(GUARD_CYCLES);
            st_n  = GUARD_CYCLES == 0 ? IDLE : GUARD;
          end else if (eoi[t]) begin
            err_n = 1'b1;
          end
        GUARD: begin
          st_n  = cnt == '0 ? IDLE : GUARD;
          cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        end
        default: st_n = IDLE;
      endcase
    end
    assign claim[t]             = clm_q;
    assign complete[t]          = cmp_q;
    assign irq_req[t]           = req_q;
    assign irq_active[t]        = act_q;
    assign eoi_err[t]           = err_q;
    assign irq_id[t*SB +: SB]   = id_q;
  end
endmodule

// File: tb/tb_plic_hw_claim_ctrl.sv
// tb_plic_hw_claim_ctrl: directed self-checking bench for plic_hw_claim_ctrl
module tb_plic_hw_claim_ctrl;
  localparam int T  = 4;
  localparam int SB = 6;
  logic HCLK = 1'b0, HRESETn;
  logic [T-1:0] hw_en, ireq, irq_ack, eoi;
  logic [T*SB-1:0] id, eoi_id;
  logic [T-1:0] claim, complete, irq_req, irq_active, eoi_err;
  logic [T*SB-1:0] irq_id;
  int checks = 0, errors = 0;

  plic_hw_claim_ctrl #(.SOURCES(35), .TARGETS(T), .GUARD_CYCLES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hw_en(hw_en), .ireq(ireq), .id(id),
    .claim(claim), .complete(complete), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .irq_active(irq_active), .eoi(eoi), .eoi_id(eoi_id),
    .eoi_err(eoi_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [SB-1:0] oid(input int t);
    return irq_id[t*SB +: SB];
  endfunction

  initial begin
    HRESETn = 1'b0; hw_en = 4'hf; ireq = '0; irq_ack = '0; eoi = '0; id = '0; eoi_id = '0;
    tick(); tick();
    chk("rst_req", irq_req, 0);
    chk("rst_act", irq_active, 0);
    chk("rst_claim", claim, 0);
    chk("rst_cmp", complete, 0);
    chk("rst_id", irq_id, 0);
    HRESETn = 1'b1;

    ireq[0] = 1'b1; id[0 +: SB] = 7;
    tick();
    chk("seq_offer", irq_req[0], 1);
    chk("seq_offer_id", oid(0), 7);
    irq_ack[0] = 1'b1;
    tick();
    chk("seq_claim", claim[0], 1);
    chk("seq_req_clr", irq_req[0], 0);
    chk("seq_active", irq_active[0], 1);
    irq_ack[0] = 1'b0; ireq[0] = 1'b0;
    tick();
    chk("seq_claim_once", claim[0], 0);
    chk("seq_act_id", oid(0), 7);
    eoi[0] = 1'b1; eoi_id[0 +: SB] = 7;
    tick();
    chk("seq_cmp", complete[0], 1);
    chk("seq_act_clr", irq_active[0], 0);
    chk("seq_id_clr", oid(0), 0);
    eoi[0] = 1'b0; ireq[0] = 1'b1; id[0 +: SB] = 8;
    tick();
    chk("seq_cmp_once", complete[0], 0);
    chk("guard1", irq_req[0], 0);
    tick();
    chk("guard2", irq_req[0], 0);
    tick();
    chk("guard3", irq_req[0], 0);
    tick();
    chk("guard_reoffer", irq_req[0], 1);
    chk("guard_reoffer_id", oid(0), 8);
    ireq[0] = 1'b0;
    tick();
    chk("wd0_req", irq_req[0], 0);

    ireq[0] = 1'b1; id[0 +: SB] = 3;
    tick();
    chk("wd_offer", irq_req[0], 1);
    ireq[0] = 1'b0;
    tick();
    chk("wd_req", irq_req[0], 0);
    chk("wd_id", oid(0), 0);
    chk("wd_noclaim", claim[0], 0);
    tick();
    chk("wd_noclaim2", claim[0], 0);
    ireq[0] = 1'b1;
    tick();
    chk("wdack_offer", irq_req[0], 1);
    ireq[0] = 1'b0; irq_ack[0] = 1'b1;
    tick();
    chk("wdack_claim", claim[0], 1);
    chk("wdack_act", irq_active[0], 1);
    irq_ack[0] = 1'b0; eoi[0] = 1'b1; eoi_id[0 +: SB] = 3;
    tick();
    chk("wdack_cmp", complete[0], 1);
    eoi[0] = 1'b0;
    repeat (4) tick();

    ireq[0] = 1'b1; id[0 +: SB] = 9;
    tick();
    irq_ack[0] = 1'b1;
    tick();
    chk("bad_claim", claim[0], 1);
    irq_ack[0] = 1'b0; ireq[0] = 1'b0; eoi[0] = 1'b1; eoi_id[0 +: SB] = 4;
    tick();
    chk("bad_err", eoi_err[0], 1);
    chk("bad_act", irq_active[0], 1);
    chk("bad_nocmp", complete[0], 0);
    eoi[0] = 1'b0;
    tick();
    chk("bad_err_once", eoi_err[0], 0);
    chk("bad_act2", irq_active[0], 1);
    eoi[0] = 1'b1; eoi_id[0 +: SB] = 9;
    tick();
    chk("good_cmp", complete[0], 1);
    chk("good_noerr", eoi_err[0], 0);
    eoi[0] = 1'b0;
    repeat (4) tick();
    eoi[0] = 1'b1;
    tick();
    chk("stray_err", eoi_err[0], 1);
    chk("stray_nocmp", complete[0], 0);
    eoi[0] = 1'b0;

    ireq[0] = 1'b1; id[0 +: SB] = 5;
    tick();
    irq_ack[0] = 1'b1;
    tick();
    chk("mid_act", irq_active[0], 1);
    irq_ack[0] = 1'b0; HRESETn = 1'b0;
    tick();
    chk("mid_rst_cmp", complete, 0);
    tick();
    chk("mid_rst_act", irq_active, 0);
    chk("mid_rst_req", irq_req, 0);
    chk("mid_rst_claim", claim, 0);
    chk("mid_rst_cmp2", complete, 0);
    HRESETn = 1'b1;
    tick();
    chk("post_rst_req", irq_req[0], 1);
    chk("post_rst_id", oid(0), 5);
    chk("post_rst_nocmp", complete[0], 0);
    ireq[0] = 1'b0;
    tick();

    hw_en[0] = 1'b0; ireq[0] = 1'b1; id[0 +: SB] = 6;
    tick(); tick();
    chk("dis_nooffer", irq_req[0], 0);
    hw_en[0] = 1'b1;
    tick();
    chk("en_offer", irq_req[0], 1);
    irq_ack[0] = 1'b1;
    tick();
    chk("en_claim", claim[0], 1);
    irq_ack[0] = 1'b0; ireq[0] = 1'b0; hw_en[0] = 1'b0;
    tick();
    chk("dis_act_hold", irq_active[0], 1);
    eoi[0] = 1'b1; eoi_id[0 +: SB] = 6;
    tick();
    chk("dis_cmp", complete[0], 1);
    eoi[0] = 1'b0; hw_en[0] = 1'b1;
    repeat (4) tick();

    id = {6'd4, 6'd3, 6'd2, 6'd1}; ireq = 4'hf;
    tick();
    chk("ind_req", irq_req, 4'hf);
    chk("ind_ids", irq_id, {6'd4, 6'd3, 6'd2, 6'd1});
    irq_ack = 4'b1000;
    tick();
    chk("ind_c3", claim, 4'b1000);
    chk("ind_id3", oid(3), 4);
    chk("ind_req3", irq_req, 4'b0111);
    irq_ack = 4'b0010;
    tick();
    chk("ind_c1", claim, 4'b0010);
    chk("ind_id1", oid(1), 2);
    irq_ack = 4'b0001;
    tick();
    chk("ind_c0", claim, 4'b0001);
    chk("ind_id0", oid(0), 1);
    irq_ack = 4'b0100;
    tick();
    chk("ind_c2", claim, 4'b0100);
    chk("ind_id2", oid(2), 3);
    irq_ack = '0;
    tick();
    chk("ind_act", irq_active, 4'hf);
    chk("ind_noclaim", claim, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
